// File: rtl/ring_link.sv
// ring_link: two independent registered elastic FIFOs closing the ring between adjacent macros,
// with per-direction delivered-beat counters and a shared busy flag.
module ring_link_fifo #(
  parameter int DataWidth = 64,
  parameter int Depth     = 2,
  parameter int CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [DataWidth-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [CntWidth-1:0]  beats_o,
  output logic                 nonempty_o
);
  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(Depth);
  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] mem_d [Depth];
  logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CntWidth-1:0]  beats_q, beats_d;
  logic                 push, pop;
  // Handshakes depend only on registered occupancy and flush, never on the far side.
  always_comb begin
    ready_o = !flush_i && cnt_q != FULL;
    valid_o = !flush_i && cnt_q != '0;
    push    = valid_i && ready_o;
    pop     = valid_o && ready_i;
    mem_d   = mem_q;
    if (push) mem_d[wptr_q] = data_i;
    wptr_d  = flush_i ? '0 : wptr_q + AW'(push);
    rptr_d  = flush_i ? '0 : rptr_q + AW'(pop);
    cnt_d   = flush_i ? '0 : cnt_q + CW'(push) - CW'(pop);
    beats_d = flush_i ? '0 : beats_q + CntWidth'(pop);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      beats_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      beats_q <= beats_d;
    end
  end
  assign data_o     = mem_q[rptr_q];
  assign beats_o    = beats_q;
  assign nonempty_o = cnt_q != '0;
endmodule

module ring_link #(
  parameter int DataWidth = 64,
  parameter int Depth     = 2,
  parameter int CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic [DataWidth-1:0] a_data_i,
  input  logic                 a_valid_i,
  output logic                 a_ready_o,
  output logic [DataWidth-1:0] b_data_o,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  input  logic [DataWidth-1:0] b_data_i,
  input  logic                 b_valid_i,
  output logic                 b_ready_o,
  output logic [DataWidth-1:0] a_data_o,
  output logic                 a_valid_o,
  input  logic                 a_ready_i,
  output logic [CntWidth-1:0]  ab_cnt_o,
  output logic [CntWidth-1:0]  ba_cnt_o,
  output logic                 busy_o
);
  logic ab_ne, ba_ne;
  ring_link_fifo #(.DataWidth(DataWidth), .Depth(Depth), .CntWidth(CntWidth)) u_ab (
    .clk_i, .rst_ni, .flush_i,
    .data_i(a_data_i), .valid_i(a_valid_i), .ready_o(a_ready_o),
    .data_o(b_data_o), .valid_o(b_valid_o), .ready_i(b_ready_i),
    .beats_o(ab_cnt_o), .nonempty_o(ab_ne)
  );
  ring_link_fifo #(.DataWidth(DataWidth), .Depth(Depth), .CntWidth(CntWidth)) u_ba (
    .clk_i, .rst_ni, .flush_i,
    .data_i(b_data_i), .valid_i(b_valid_i), .ready_o(b_ready_o),
    .data_o(a_data_o), .valid_o(a_valid_o), .ready_i(a_ready_i),
    .beats_o(ba_cnt_o), .nonempty_o(ba_ne)
  );
  assign busy_o = ab_ne || ba_ne;
endmodule

// File: tb/tb_ring_link.sv
// tb_ring_link: directed and random stimulus for ring_link, checked against a queue-based model.
module tb_ring_link;
  localparam int DW = 64;
  localparam int D  = 2;
  logic clk = 0, rst_n = 0, flush = 0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic a_valid = 0, b_valid = 0, a_ready = 0, b_ready = 0;
  logic [DW-1:0] a_data_o, b_data_o;
  logic a_valid_o, b_valid_o, a_ready_o, b_ready_o, busy;
  logic [15:0] ab_cnt, ba_cnt;
  logic w_valid = 0, w_ready = 0;
  logic [DW-1:0] w_bdata, w_adata;
  logic w_aready, w_bvalid, w_bready, w_avalid, w_busy;
  logic [3:0] w_ab, w_ba;
  int errors = 0, checks = 0;
  bit chk_on = 0;

  ring_link #(.DataWidth(DW), .Depth(D), .CntWidth(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .a_data_i(a_data), .a_valid_i(a_valid), .a_ready_o(a_ready_o),
    .b_data_o(b_data_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready),
    .b_data_i(b_data), .b_valid_i(b_valid), .b_ready_o(b_ready_o),
    .a_data_o(a_data_o), .a_valid_o(a_valid_o), .a_ready_i(a_ready),
    .ab_cnt_o(ab_cnt), .ba_cnt_o(ba_cnt), .busy_o(busy)
  );

  ring_link #(.DataWidth(DW), .Depth(D), .CntWidth(4)) dut_w (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(1'b0),
    .a_data_i(64'h5), .a_valid_i(w_valid), .a_ready_o(w_aready),
    .b_data_o(w_bdata), .b_valid_o(w_bvalid), .b_ready_i(w_ready),
    .b_data_i(64'h0), .b_valid_i(1'b0), .b_ready_o(w_bready),
    .a_data_o(w_adata), .a_valid_o(w_avalid), .a_ready_i(1'b1),
    .ab_cnt_o(w_ab), .ba_cnt_o(w_ba), .busy_o(w_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Model: each direction is a bounded queue; counters are total pops.
  logic [DW-1:0] q_ab[$], q_ba[$];
  int tot_ab = 0, tot_ba = 0, w_occ = 0, w_tot = 0;
  bit m_pu, m_po, w_pu, w_po;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_ab.delete(); q_ba.delete();
      tot_ab = 0; tot_ba = 0; w_occ = 0; w_tot = 0;
    end else begin
      w_pu = w_valid && w_occ < D;
      w_po = w_occ > 0 && w_ready;
      w_occ = w_occ + int'(w_pu) - int'(w_po);
      if (w_po) w_tot++;
      if (flush) begin
        q_ab.delete(); q_ba.delete();
        tot_ab = 0; tot_ba = 0;
      end else begin
        m_pu = a_valid && q_ab.size() < D;
        m_po = q_ab.size() > 0 && b_ready;
        if (m_po) begin void'(q_ab.pop_front()); tot_ab++; end
        if (m_pu) q_ab.push_back(a_data);
        m_pu = b_valid && q_ba.size() < D;
        m_po = q_ba.size() > 0 && a_ready;
        if (m_po) begin void'(q_ba.pop_front()); tot_ba++; end
        if (m_pu) q_ba.push_back(b_data);
      end
    end
  end

  logic [DW-1:0] got_ab[$];
  always @(posedge clk) if (rst_n && b_valid_o && b_ready) got_ab.push_back(b_data_o);

  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      chk("a_ready_o", a_ready_o, !flush && q_ab.size() < D);
      chk("b_valid_o", b_valid_o, !flush && q_ab.size() > 0);
      if (!flush && q_ab.size() > 0) chk("b_data_o", b_data_o, q_ab[0]);
      chk("b_ready_o", b_ready_o, !flush && q_ba.size() < D);
      chk("a_valid_o", a_valid_o, !flush && q_ba.size() > 0);
      if (!flush && q_ba.size() > 0) chk("a_data_o", a_data_o, q_ba[0]);
      chk("ab_cnt_o", ab_cnt, 64'(16'(tot_ab)));
      chk("ba_cnt_o", ba_cnt, 64'(16'(tot_ba)));
      chk("busy_o", busy, q_ab.size() > 0 || q_ba.size() > 0);
      chk("w_cnt", w_ab, 64'(w_tot % 16));
    end
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk_on = 1;
    chk("rst_a_ready", a_ready_o, 1);
    chk("rst_b_ready", b_ready_o, 1);
    chk("rst_valids", {a_valid_o, b_valid_o}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnts", {ab_cnt, ba_cnt}, 0);
    chk("rst_data", a_data_o | b_data_o, 0);

    b_ready = 1; a_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      a_valid = 1; a_data = 64'(i);
      step();
      if (i == 1) begin
        chk("lat_valid", b_valid_o, 1);
        chk("lat_data", b_data_o, 1);
      end
    end
    a_valid = 0;
    repeat (3) step();
    chk("stream_n", got_ab.size(), 8);
    for (int i = 0; i < 8 && i < got_ab.size(); i++) chk("stream_beat", got_ab[i], 64'(i + 1));
    chk("stream_ab_cnt", ab_cnt, 8);
    chk("stream_ba_cnt", ba_cnt, 0);

    got_ab.delete();
    b_ready = 0;
    a_valid = 1; a_data = 'hA; step();
    a_data = 'hB; step();
    a_data = 'hC;
    chk("bp_full_ready", a_ready_o, 0);
    b_ready = 1; step();
    chk("bp_ready_back", a_ready_o, 1);
    step();
    a_valid = 0;
    repeat (3) step();
    chk("bp_n", got_ab.size(), 3);
    if (got_ab.size() == 3) begin
      chk("bp_0", got_ab[0], 'hA);
      chk("bp_1", got_ab[1], 'hB);
      chk("bp_2", got_ab[2], 'hC);
    end

    b_ready = 0;
    a_valid = 1; a_data = 'h11; step();
    a_data = 'h12; step();
    got_ab.delete();
    flush = 1; a_data = 'h13; b_ready = 1;
    #1;
    chk("fl_readies", {a_ready_o, b_ready_o}, 0);
    chk("fl_valids", {a_valid_o, b_valid_o}, 0);
    step();
    flush = 0; a_valid = 0;
    chk("fl_busy", busy, 0);
    chk("fl_ab_cnt", ab_cnt, 0);
    repeat (3) step();
    chk("fl_nothing_out", got_ab.size(), 0);

    n = 0;
    while (n < 20000 && !(tot_ab >= 1000 && tot_ba >= 1000)) begin
      a_valid = $urandom_range(0, 3) != 0;
      b_valid = $urandom_range(0, 3) != 0;
      a_data = {$urandom, $urandom};
      b_data = {$urandom, $urandom};
      a_ready = $urandom_range(0, 2) != 0;
      b_ready = $urandom_range(0, 2) != 0;
      step();
      n++;
    end
    chk("duplex_done", tot_ab >= 1000 && tot_ba >= 1000, 1);
    a_valid = 0; b_valid = 0; a_ready = 1; b_ready = 1;
    repeat (4) step();
    chk("duplex_drained", busy, 0);

    b_ready = 0; a_valid = 1; a_data = 'h77;
    step(); step();
    #2 rst_n = 0;
    #1;
    chk("mid_rst_valid", b_valid_o, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", b_data_o, 0);
    chk("mid_rst_ready", a_ready_o, 1);
    a_valid = 0;
    @(posedge clk);
    #1 rst_n = 1;

    w_valid = 1; w_ready = 1;
    repeat (17) step();
    w_valid = 0;
    repeat (3) step();
    chk("wrap_cnt", w_ab, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ring_link.md
# ring_link

Elastic pipeline link closing the ring between two adjacent `ara_macro` instances. It is the receiving end of one macro's ring outputs and the transmitting end into the neighbour macro's ring inputs. Two independent directions are carried:
- A→B: macro A's `ring_data_r_o` to macro B's `ring_data_l_i`.
- B→A: macro B's `ring_data_l_o` to macro A's `ring_data_r_i`.

Each direction has a registered FIFO, so no combinational path crosses macro boundaries. Per-direction beat counters and a busy flag support ring-drain checks by the SLDU sequencing logic.

## Interface
Parameters:
- `DataWidth`, 64: ring beat width, equal to `$bits(elen_t)`.
- `Depth`, 2: FIFO entries per direction; power of two, ≥2.
- `CntWidth`, 16: width of each beat counter.

Ports:
- `clk_i` in 1: clock; single clock domain.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: synchronous clear of both FIFOs and both counters.
- `a_data_i` in DataWidth: from A's `ring_data_r_o`.
- `a_valid_i` in 1: from A's `ring_data_r_valid_o`.
- `a_ready_o` out 1: to A's `ring_data_r_ready_i`.
- `b_data_o` out DataWidth: to B's `ring_data_l_i`.
- `b_valid_o` out 1: to B's `ring_data_l_valid_i`.
- `b_ready_i` in 1: from B's `ring_data_l_ready_o`.
- `b_data_i` in DataWidth: from B's `ring_data_l_o`.
- `b_valid_i` in 1: from B's `ring_data_l_valid_o`.
- `b_ready_o` out 1: to B's `ring_data_l_ready_i`.
- `a_data_o` out DataWidth: to A's `ring_data_r_i`.
- `a_valid_o` out 1: to A's `ring_data_r_valid_i`.
- `a_ready_i` in 1: from A's `ring_data_r_ready_o`.
- `ab_cnt_o` out CntWidth: beats delivered A→B since reset/flush.
- `ba_cnt_o` out CntWidth: beats delivered B→A since reset/flush.
- `busy_o` out 1: either FIFO non-empty.

## Operation
The two directions are identical and share no state except `flush_i`. The description below is for A→B.
- Storage: `Depth` entries, read and write pointers of `$clog2(Depth)` bits (wrap-around), occupancy count of `$clog2(Depth)+1` bits.
- Push: `a_valid_i && a_ready_o`. Pop: `b_valid_o && b_ready_i`.
- `a_ready_o` = (count != Depth), driven from registered count only.
  - A push in the same cycle as a pop while full is not accepted.
  - No ready path ever passes through the link combinationally.
- `b_valid_o` = (count != 0). `b_data_o` = entry at the read pointer; the entry is driven from a flop, so there is no input-to-output combinational path.
- Simultaneous push and pop with 0 < count < Depth: count unchanged, both pointers advance.
- Push with count == 0: the data is not visible at the output that cycle; it appears the next cycle.
- Ordering is strict FIFO; no beat is dropped or duplicated.
- `ab_cnt_o` increments by 1 on every pop and wraps modulo 2^CntWidth.
- `busy_o` = (A→B count != 0) || (B→A count != 0).
- `flush_i` high:
  - Next edge: pointers, counts and counters go to 0.
  - During the flush cycle: `a_ready_o` = `b_ready_o` = 0 and `a_valid_o` = `b_valid_o` = 0, regardless of contents. A pop cannot occur in that cycle.
  - Flush takes priority over simultaneous push/pop; nothing pushed in that cycle is retained.

## Timing
- Reset values (asynchronous assert, deassert on edge):
  - All counts, pointers and counters 0.
  - `a_valid_o` = `b_valid_o` = 0; `a_ready_o` = `b_ready_o` = 1; `busy_o` = 0.
  - `a_data_o` = `b_data_o` = 0, because storage is reset to 0.
- Latency: a beat accepted at edge N is valid at the output from cycle N+1 (1-cycle latency).
- Throughput: 1 beat/cycle sustained for Depth ≥ 2 with the consumer always ready.
- Backpressure: with the consumer stalled, exactly Depth beats are accepted. Ready drops in the cycle after the Depth-th push and rises in the cycle after the first pop.
- Valid/data stability: once `b_valid_o` is asserted, it and `b_data_o` hold until the pop (AXI-style). The only exceptions are flush and reset.
- Reset mid-transfer: contents are discarded immediately and outputs take their reset values asynchronously.

## Test plan
- **Reset:** drive `rst_ni` = 0 then release → all valids 0, readies 1, counters 0, `busy_o` = 0.
- **Stream:** push 0x1..0x8 on `a_data_i` with `b_ready_i` = 1 every cycle → `b_data_o` delivers 0x1..0x8 in order, one per cycle with 1-cycle lag; `ab_cnt_o` = 8; `ba_cnt_o` = 0.
- **Backpressure:** `b_ready_i` = 0 and push 0xA, 0xB, 0xC (Depth = 2) → only 0xA and 0xB are accepted, `a_ready_o` = 0. Then raise `b_ready_i` → 0xA, 0xB, 0xC are delivered, and `a_ready_o` returns to 1 one cycle after the first pop.
- **Full-duplex:** random valid/ready on both directions for 1000 beats → each direction is an in-order, lossless scoreboard match; counters equal the beat counts mod 2^16.
- **Flush:** fill A→B with 2 beats, then assert `flush_i` together with `a_valid_i` = 1 → valids and readies are 0 in the flush cycle. The next cycle shows count 0, `busy_o` = 0, `ab_cnt_o` = 0, and no beat is ever delivered to B.
- **Counter wrap:** CntWidth = 4, deliver 17 beats → `ab_cnt_o` = 1.
